rgb_frame_capture: RTL and testbench
====================================

Name: rgb_frame_capture

Overview:
- Receive-side counterpart of our LCD timing/pixel generator. Samples a parallel RGB565 video stream qualified by LCD_DE and LCD_VSYNC.
- Rebuilds pixel and line coordinates and crops a fixed window.
- Converts each cropped pixel to 8-bit grayscale and writes it into a single-port frame buffer (pROM/BSRAM-style write port). Sits between the camera/LCD video bus and the image-memory blocks.

Parameters:
- IMG_W, 390: cropped window width in pixels.
- IMG_H, 240: cropped window height in lines.
- X_OFFSET, 205: first captured pixel index within a DE-active line.
- Y_OFFSET, 120: first captured line index within a frame.
- VS_POL, 1: asserted level of LCD_VSYNC during the vertical sync pulse.
- ADDR_W, 17: frame-buffer address width. IMG_W*IMG_H must be less than or equal to 2^ADDR_W.

Ports:
- PixelClk  in  1  pixel clock; all logic on its rising edge.
- nRST  in  1  asynchronous active-low reset.
- capture_en  in  1  level; request continuous frame capture.
- LCD_DE  in  1  data enable; pixel valid when high.
- LCD_VSYNC  in  1  vertical sync; polarity set by VS_POL.
- LCD_R  in  5  red.
- LCD_G  in  6  green.
- LCD_B  in  5  blue.
- wr_en  out  1  frame-buffer write strobe, one cycle per pixel.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8  grayscale pixel.
- frame_done  out  1  one-cycle pulse after a complete captured frame.
- frame_width  out  11  DE-high pixel count of the last line of the last frame.
- frame_height  out  11  DE lines counted in the last frame.
- busy  out  1  high in SYNC or CAPTURE.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; input registers 0.
- Input stage: LCD_DE, LCD_VSYNC, LCD_R/G/B registered once.
- vs_start: the registered VSYNC changes into level VS_POL (edge detect on registered copy).
- de_fall: registered DE goes 1 to 0.
- x counter (11 b):
  - Increments on each registered DE-high cycle.
  - Clears to 0 on de_fall.
  - On de_fall, the pre-clear value goes to line_w_last.
- y counter (11 b):
  - Increments on de_fall.
  - Clears on vs_start.
- Capture window: X_OFFSET <= x < X_OFFSET+IMG_W and Y_OFFSET <= y < Y_OFFSET+IMG_H, with DE high. x and y are values before the increment for that pixel.
- Address:
  - Incremental counter, no multiplier.
  - Cleared on vs_start.
  - Increments after each in-window pixel.
  - First in-window pixel gets address 0; last gets IMG_W*IMG_H-1.
  - Never wraps; further in-window pixels cannot occur by construction.
- Grayscale:
  - Expand channels: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
  - gray = (77*R8 + 150*G8 + 29*B8) >> 8, using a 16-bit sum (max 65280, no overflow).
  - Stage A registers the three products; stage B registers the sum and shift.
- Latency: a pixel on the input pins at edge k appears as wr_en=1 with its wr_addr/wr_data after edge k+3. Address and enable are pipelined alongside the data.
- FSM:
  - IDLE: busy=0, no writes. capture_en=1 -> SYNC.
  - SYNC: wait for vs_start -> CAPTURE. Any partial frame in progress is discarded.
  - CAPTURE: writes enabled. On the next vs_start:
    - Pulse frame_done for one cycle, 3 cycles later so it follows the final write.
    - Latch frame_height=y and frame_width=line_w_last.
    - Stay in CAPTURE if capture_en=1, else go to IDLE.
- capture_en drops mid-frame: the current frame completes, then IDLE.
- capture_en re-raised in IDLE: must pass through SYNC. No capture starts mid-frame.
- Frame ending early (vs_start before IMG_H window lines): frame_done still pulses; frame_height reports the short count; unwritten addresses keep old contents.
- Simultaneous de_fall and vs_start: vs_start wins for y (y=0). line_w_last still updates.
- Pixels still in the pipeline when the state leaves CAPTURE are still written. Pipeline enables are decided at stage entry.
- nRST low at any time: immediate clear. wr_en drops asynchronously; partial frame abandoned.

Test Plan:
- Reset: nRST low with stimulus toggling -> all outputs 0 and no wr_en. Release, capture_en=0 -> busy stays 0.
- Full frame:
  - Stimulus: 800x480 DE-active lines, VS_POL=1 sync pulse, capture_en=1, one-frame preroll.
  - Required: exactly 93600 wr_en pulses, addresses 0..93599 contiguous.
  - Required: first write is line 120 pixel 205, arriving 3 cycles after it is presented.
  - Required: frame_done pulses once after the last write; frame_width=800, frame_height=480.
- Gray math:
  - R=31,G=63,B=31 -> wr_data=255.
  - R=0,G=0,B=0 -> 0.
  - R=31,G=0,B=0 -> 76.
  - R=0,G=63,B=0 -> 149.
  - R=0,G=0,B=31 -> 28.
- Mid-frame enable: raise capture_en at line 200 -> no writes until the next vs_start; then a full frame.
  - Drop capture_en at line 300 -> that frame completes (93600 writes), then IDLE with busy=0.
- Short frame: vs_start after 250 lines -> 390*130=50700 writes, frame_done pulse, frame_height=250.
- Async reset mid-CAPTURE at line 200 -> wr_en=0 immediately. After release and capture_en=1, the next frame starts again at address 0.

Source files
------------

// File: rtl/rgb_frame_capture.sv
// rgb_frame_capture: samples an RGB565 video bus qualified by DE/VSYNC and
// rebuilds pixel/line coordinates. It crops a fixed window, converts each
// cropped pixel to 8-bit gray and streams it to a frame-buffer write port.
// Frame statistics and a frame_done pulse are reported per captured frame.
module rgb_frame_capture #(
  parameter int IMG_W    = 390,
  parameter int IMG_H    = 240,
  parameter int X_OFFSET = 205,
  parameter int Y_OFFSET = 120,
  parameter int VS_POL   = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic              capture_en,
  input  logic              LCD_DE,
  input  logic              LCD_VSYNC,
  input  logic [4:0]        LCD_R,
  input  logic [5:0]        LCD_G,
  input  logic [4:0]        LCD_B,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic [10:0]       frame_width,
  output logic [10:0]       frame_height,
  output logic              busy
);

  localparam logic        VS_LVL = 1'(VS_POL);
  localparam logic [10:0] X_LO   = 11'(X_OFFSET);
  localparam logic [10:0] X_HI   = 11'(X_OFFSET + IMG_W);
  localparam logic [10:0] Y_LO   = 11'(Y_OFFSET);
  localparam logic [10:0] Y_HI   = 11'(Y_OFFSET + IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CAPTURE} state_t;

  state_t r_state, w_state_nxt;

  logic              r_de, r_de_d, r_vs, r_vs_d;
  logic [4:0]        r_r, r_b;
  logic [5:0]        r_g;
  logic [10:0]       r_x, r_y, r_line_w;
  logic [ADDR_W-1:0] r_addr;
  logic [10:0]       r_frame_w, r_frame_h;

  // vld/done/addr travel three stages so they line up with the gray result
  logic [2:0]             r_vld_pipe, r_done_pipe;
  logic [2:0][ADDR_W-1:0] r_addr_pipe;
  logic [15:0]            r_pr, r_pg, r_pb;
  logic [7:0]             r_gray1, r_gray2;

  logic        w_vs_start, w_de_fall, w_in_win, w_wr, w_frame_end;
  logic [7:0]  w_r8, w_g8, w_b8;
  logic [15:0] w_sum;

  assign w_vs_start = (r_vs == VS_LVL) && (r_vs_d != VS_LVL);
  assign w_de_fall  = r_de_d & ~r_de;
  assign w_in_win   = r_de && (r_x >= X_LO) && (r_x < X_HI) &&
                      (r_y >= Y_LO) && (r_y < Y_HI);
  assign w_wr       = w_in_win && (r_state == S_CAPTURE);

  // bit replication spreads 5/6-bit channels over the full 8-bit range
  assign w_r8  = {r_r, r_r[4:2]};
  assign w_g8  = {r_g, r_g[5:4]};
  assign w_b8  = {r_b, r_b[4:2]};
  assign w_sum = r_pr + r_pg + r_pb;

  assign wr_en        = r_vld_pipe[2];
  assign wr_addr      = r_addr_pipe[2];
  assign wr_data      = r_gray2;
  assign frame_done   = r_done_pipe[2];
  assign frame_width  = r_frame_w;
  assign frame_height = r_frame_h;
  assign busy         = (r_state != S_IDLE);

  // input stage: one register on every video pin, plus delayed copies for edges
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_de   <= 1'b0;
      r_de_d <= 1'b0;
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
    end else begin
      r_de   <= LCD_DE;
      r_de_d <= r_de;
      r_vs   <= LCD_VSYNC;
      r_vs_d <= r_vs;
      r_r    <= LCD_R;
      r_g    <= LCD_G;
      r_b    <= LCD_B;
    end
  end

  // pixel/line coordinates and the running frame-buffer address
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_x      <= '0;
      r_y      <= '0;
      r_line_w <= '0;
      r_addr   <= '0;
    end else begin
      if (w_de_fall) begin
        r_x      <= '0;
        r_line_w <= r_x;
      end else if (r_de) begin
        r_x <= r_x + 11'd1;
      end
      // vsync wins over a coincident line end
      if (w_vs_start)     r_y <= '0;
      else if (w_de_fall) r_y <= r_y + 11'd1;
      if (w_vs_start)     r_addr <= '0;
      else if (w_wr)      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // state register
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state; a frame only ends on vsync while capturing
  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:    if (capture_en) w_state_nxt = S_SYNC;
      S_SYNC:    if (w_vs_start) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_vs_start) begin
        w_frame_end = 1'b1;
        if (!capture_en) w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // frame statistics latched at the vsync that closes a captured frame
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_frame_w <= '0;
      r_frame_h <= '0;
    end else if (w_frame_end) begin
      r_frame_h <= r_y + 11'(w_de_fall);
      r_frame_w <= w_de_fall ? r_x : r_line_w;
    end
  end

  // 3-stage write pipeline: products, weighted sum, output register
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      r_vld_pipe  <= '0;
      r_done_pipe <= '0;
      r_addr_pipe <= '0;
      r_pr        <= '0;
      r_pg        <= '0;
      r_pb        <= '0;
      r_gray1     <= '0;
      r_gray2     <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[1:0], w_wr};
      r_done_pipe <= {r_done_pipe[1:0], w_frame_end};
      r_addr_pipe <= {r_addr_pipe[1:0], r_addr};
      r_pr        <= {8'd0, w_r8} * 16'd77;
      r_pg        <= {8'd0, w_g8} * 16'd150;
      r_pb        <= {8'd0, w_b8} * 16'd29;
      r_gray1     <= w_sum[15:8];
      r_gray2     <= r_gray1;
    end
  end

endmodule

// File: tb/tb_rgb_frame_capture.sv
// Bench for rgb_frame_capture with a reduced window so whole frames stay short.
// The model predicts every write (address, gray value, arrival cycle) and every
// frame_done from frame/line/pixel indices; one process compares each cycle.
module tb_rgb_frame_capture;
  localparam int IW = 6, IH = 4, XO = 3, YO = 2, AW = 5;

  logic          PixelClk = 1'b0, nRST = 1'b0, capture_en = 1'b0;
  logic          LCD_DE = 1'b0, LCD_VSYNC = 1'b0;
  logic [4:0]    LCD_R = '0, LCD_B = '0;
  logic [5:0]    LCD_G = '0;
  logic          wr_en, frame_done, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [10:0]   frame_width, frame_height;

  rgb_frame_capture #(.IMG_W(IW), .IMG_H(IH), .X_OFFSET(XO), .Y_OFFSET(YO),
                      .VS_POL(1), .ADDR_W(AW)) dut (
    .PixelClk(PixelClk), .nRST(nRST), .capture_en(capture_en),
    .LCD_DE(LCD_DE), .LCD_VSYNC(LCD_VSYNC), .LCD_R(LCD_R), .LCD_G(LCD_G),
    .LCD_B(LCD_B), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_width(frame_width),
    .frame_height(frame_height), .busy(busy));

  always #5 PixelClk = ~PixelClk;

  int cyc = 0;
  always @(posedge PixelClk) cyc <= cyc + 1;

  typedef struct { int cy; int addr; int data; } wr_t;
  typedef struct { int cy; int h; int w; int n; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int checks = 0, errors = 0;
  int mstate = 0;            // 0 idle, 1 waiting for frame start, 2 capturing
  int fcnt = 0, prev_lines = 0, prev_lw = 0;
  int last_frame_writes = 0, wr_cnt = 0;
  int dut_mem [32];
  int gr [5] = '{31, 0, 31, 0, 0};
  int gg [5] = '{63, 0, 0, 63, 0};
  int gb [5] = '{31, 0, 0, 0, 31};
  int gexp [5] = '{255, 0, 76, 149, 28};

  function automatic int gray_m(int r, int g, int b);
    int r8, g8, b8;
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drv(input logic de, input logic vs, input int r, input int g, input int b);
    @(negedge PixelClk);
    LCD_DE = de; LCD_VSYNC = vs;
    LCD_R = 5'(r); LCD_G = 6'(g); LCD_B = 5'(b);
  endtask

  // One frame: vsync pulse, porch, nlines DE lines of lw pixels with blanking.
  task automatic send_frame(input int nlines, input int lw, input int en_line,
                            input bit en_val, input int rst_line, input bit gray);
    int r, g, b;
    drv(1'b0, 1'b1, 0, 0, 0);
    if (mstate == 2) begin
      dq.push_back('{cyc + 4, prev_lines, prev_lw, fcnt});
      if (!capture_en) mstate = 0;
    end else if (mstate == 1) mstate = 2;
    fcnt = 0;
    drv(1'b0, 1'b1, 0, 0, 0);
    repeat (2) drv(1'b0, 1'b0, 0, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      if (l == en_line) begin
        chk("busy_before_en_change", busy, 64'(mstate != 0));
        capture_en = en_val;
        if (en_val && mstate == 0) mstate = 1;
      end
      for (int p = 0; p < lw; p++) begin
        r = $urandom_range(31); g = $urandom_range(63); b = $urandom_range(31);
        if (gray && l == YO && p >= XO && p < XO + 5) begin
          r = gr[p-XO]; g = gg[p-XO]; b = gb[p-XO];
        end
        drv(1'b1, 1'b0, r, g, b);
        if (mstate == 2 && l >= YO && l < YO + IH && p >= XO && p < XO + IW) begin
          wq.push_back('{cyc + 4, (l - YO) * IW + (p - XO), gray_m(r, g, b)});
          fcnt++;
        end
        if (l == rst_line && p == XO + 4) begin
          #2;
          chk("wr_en_before_reset", wr_en, 1);
          nRST = 1'b0;
          wq.delete(); dq.delete(); fcnt = 0; mstate = 0;
          #1;
          chk("wr_en_async_reset", wr_en, 0);
          chk("busy_async_reset", busy, 0);
          chk("wr_addr_async_reset", wr_addr, 0);
        end
      end
      repeat (3) drv(1'b0, 1'b0, 0, 0, 0);
      if (l == rst_line) begin
        @(negedge PixelClk);
        nRST = 1'b1;
        if (capture_en) mstate = 1;
      end
    end
    prev_lines = nlines; prev_lw = lw;
    chk("busy_frame_end", busy, 64'(mstate != 0));
  endtask

  // compare process: every cycle, DUT writes and frame_done against the model
  initial begin
    wr_t e;
    dn_t d;
    forever begin
      @(negedge PixelClk);
      if (!nRST) wr_cnt = 0;
      if (wr_en) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("wr_cycle", cyc, e.cy);
          dut_mem[wr_addr] = int'(wr_data);
          wr_cnt++;
        end
      end else if (wq.size() > 0 && wq[0].cy <= cyc) begin
        chk("missing_write", 0, 1);
        wq.delete(0);
      end
      if (frame_done) begin
        if (dq.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          d = dq.pop_front();
          chk("frame_done_cycle", cyc, d.cy);
          chk("frame_height", frame_height, d.h);
          chk("frame_width", frame_width, d.w);
          chk("frame_write_count", wr_cnt, d.n);
        end
        last_frame_writes = wr_cnt;
        wr_cnt = 0;
      end else if (dq.size() > 0 && dq[0].cy <= cyc) begin
        chk("missing_frame_done", 0, 1);
        dq.delete(0);
      end
    end
  end

  initial begin
    int lw;
    // reset held while the bus toggles: every output stays zero
    repeat (8) begin
      drv(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(31),
          $urandom_range(63), $urandom_range(31));
      capture_en = 1'($urandom_range(1));
      #1;
      chk("reset_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_width,
                            frame_height, busy}, 0);
    end
    drv(1'b0, 1'b0, 0, 0, 0);
    capture_en = 1'b0;
    nRST = 1'b1;
    send_frame(8, 12, -1, 1'b0, -1, 1'b0);            // idle frame, busy stays 0
    send_frame(8, 12, 0, 1'b1, -1, 1'b0);             // preroll, enable at line 0
    lw = $urandom_range(14, 10);
    send_frame(8, lw, -1, 1'b0, -1, 1'b0);            // first captured frame
    send_frame(8, 11, -1, 1'b0, -1, 1'b1);            // gray-pattern frame
    chk("full_frame_writes", last_frame_writes, 24);
    chk("full_frame_height", frame_height, 8);
    chk("full_frame_width", frame_width, 64'(lw));
    for (int i = 0; i < 5; i++) chk("gray_literal", dut_mem[i], gexp[i]);
    send_frame(8, 12, 6, 1'b0, -1, 1'b0);             // drop enable mid-frame
    send_frame(8, 12, 3, 1'b1, -1, 1'b0);             // idle, re-enable mid-frame
    send_frame(8, $urandom_range(14, 10), -1, 1'b0, -1, 1'b0);
    send_frame(4, 13, -1, 1'b0, -1, 1'b0);            // short frame
    send_frame(8, 10, -1, 1'b0, -1, 1'b0);
    chk("short_frame_writes", last_frame_writes, 12);
    chk("short_frame_height", frame_height, 4);
    send_frame(8, 12, -1, 1'b0, 3, 1'b0);             // async reset mid-capture
    send_frame(8, $urandom_range(14, 10), -1, 1'b0, -1, 1'b0);
    send_frame(0, 0, -1, 1'b0, -1, 1'b0);             // closing vsync
    repeat (10) drv(1'b0, 1'b0, 0, 0, 0);
    chk("pending_writes_left", wq.size(), 0);
    chk("pending_done_left", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
